fp16_vec_packer: RTL and testbench

- Upstream feeder for the 128-input FP16 adder tree.
- Collects a vector of N FP16 elements arriving LANES per beat over a valid/ready stream and zero-pads short vectors terminated by in_last.
- Presents the whole vector on a flat bus with a single-cycle valid pulse that drives the tree's valid_in.
- Holds the vector while out_hold is high, because the tree has no ready.

---
 rtl/fp16_vec_packer_pkg.sv | 22 ++
 rtl/fp16_vec_packer.sv | 117 +++++++++++
 tb/tb_fp16_vec_packer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_vec_packer_pkg.sv
// Constants shared by the FP16 vector packer and the adder tree it feeds.
// DW / FP16_ZERO fix the element format; DefaultN / DefaultLanes are the
// standard tree geometry; calc_beats and calc_count_w derive the beat count
// and element-count width from that geometry so both blocks agree.
package fp16_vec_packer_pkg;

  localparam int unsigned DW           = 16;
  localparam logic [DW-1:0] FP16_ZERO  = 16'h0000;
  localparam int unsigned DefaultN     = 128;
  localparam int unsigned DefaultLanes = 16;

  // Beats needed for one full vector; n is expected to be a multiple of lanes.
  function automatic int unsigned calc_beats(input int unsigned n, input int unsigned lanes);
    return n / lanes;
  endfunction

  // Width able to hold any count 0..n.
  function automatic int unsigned calc_count_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fp16_vec_packer.sv
// Collects N FP16 elements arriving LANES per beat on a valid/ready stream and
// presents the whole vector on a flat bus with a one-cycle valid pulse for the
// adder tree. Short vectors (in_last_i before the final beat) are zero padded.
// The tree has no ready, so out_hold_i freezes the packed vector and blocks
// further input until it is released.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input beat valid
//   in_ready_o   packer can accept a beat
//   in_data_i    beat payload, lane j at [(j+1)*DW-1 -: DW]
//   in_last_i    beat ends the vector
//   out_hold_i   downstream stalls release of the packed vector
//   out_flat_o   packed vector, element i at [(i+1)*DW-1 -: DW]
//   out_valid_o  one-cycle pulse, packed vector valid
//   out_count_o  number of real (non-padded) elements in out_flat_o
module fp16_vec_packer
  import fp16_vec_packer_pkg::*;
#(
  // N must be a multiple of LANES.
  parameter int unsigned N     = DefaultN,
  parameter int unsigned LANES = DefaultLanes
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [LANES*DW-1:0]             in_data_i,
  input  logic                            in_last_i,
  input  logic                            out_hold_i,
  output logic [N*DW-1:0]                 out_flat_o,
  output logic                            out_valid_o,
  output logic [calc_count_w(N)-1:0]      out_count_o
);

  localparam int unsigned BEATS  = calc_beats(N, LANES);
  localparam int unsigned BcW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CountW = calc_count_w(N);
  localparam int unsigned BeatW  = LANES * DW;
  localparam logic [BcW-1:0] LastBeat = BcW'(BEATS - 1);

  logic [BcW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [N*DW-1:0]   buf_q, buf_d;
  logic [N*DW-1:0]   flat_q, flat_d;
  logic [CountW-1:0] count_q, count_d;
  logic              pending_q, pending_d;

  logic              accept;
  logic              complete;
  logic [N*DW-1:0]   merged;  // assembly buffer with the current beat dropped in
  logic [N*DW-1:0]   padded;  // merged with every beat after the current one zeroed

  assign in_ready_o  = !pending_q || !out_hold_i;
  assign out_valid_o = pending_q && !out_hold_i;
  assign accept      = in_valid_i && in_ready_o;
  assign complete    = accept && ((beat_cnt_q == LastBeat) || in_last_i);

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    localparam logic [BcW-1:0] BeatIdx = BcW'(b);
    assign merged[b*BeatW +: BeatW] = (beat_cnt_q == BeatIdx) ? in_data_i
                                                               : buf_q[b*BeatW +: BeatW];
    if (b == 0) begin : g_first
      // Beat 0 is always part of a completed vector.
      assign padded[b*BeatW +: BeatW] = merged[b*BeatW +: BeatW];
    end else begin : g_rest
      assign padded[b*BeatW +: BeatW] = (beat_cnt_q >= BeatIdx) ? merged[b*BeatW +: BeatW]
                                                                 : {LANES{FP16_ZERO}};
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    buf_d      = buf_q;
    flat_d     = flat_q;
    count_d    = count_q;
    pending_d  = pending_q;

    if (out_valid_o) begin
      pending_d = 1'b0;
    end

    if (accept) begin
      if (complete) begin
        // A completion on the release edge overrides the clear above.
        flat_d     = padded;
        count_d    = CountW'((32'(beat_cnt_q) + 32'd1) * LANES);
        pending_d  = 1'b1;
        beat_cnt_d = '0;
        buf_d      = '0;
      end else begin
        buf_d      = merged;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      buf_q      <= '0;
      flat_q     <= '0;
      count_q    <= '0;
      pending_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      buf_q      <= buf_d;
      flat_q     <= flat_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
    end
  end

  assign out_flat_o  = flat_q;
  assign out_count_o = count_q;

endmodule

// File: tb/tb_fp16_vec_packer.sv
module tb_fp16_vec_packer;

  localparam int N     = 128;
  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int BEATS = N / LANES;
  localparam int CW    = 8;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic                in_last;
  logic                out_hold;
  logic [N*DW-1:0]     out_flat;
  logic                out_valid;
  logic [CW-1:0]       out_count;

  fp16_vec_packer #(.N(N), .LANES(LANES)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_hold_i  (out_hold),
    .out_flat_o  (out_flat),
    .out_valid_o (out_valid),
    .out_count_o (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N*DW-1:0] flat;
    logic [CW-1:0]   count;
    int              due;
    bit              chk_lat;
  } exp_t;

  typedef struct {
    int          nbeats;
    logic [15:0] base;
    bit          inc;
    bit          last_full;
    int          exp_count;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  int   tests  = 0;
  int   fails  = 0;
  int   pulses = 0;
  int   pushed = 0;

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_flat(input string name, input logic [N*DW-1:0] act,
                            input logic [N*DW-1:0] exp);
    int first;
    tests++;
    if (act !== exp) begin
      fails++;
      first = -1;
      for (int i = N - 1; i >= 0; i--)
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) first = i;
      $display("FAIL %s: elem %0d got %h want %h (cycle %0d)", name, first,
               act[first*DW +: DW], exp[first*DW +: DW], cyc);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest completed vector.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      exp_t e;
      pulses++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got pulse want none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check_flat("out_flat", out_flat, e.flat);
        check_val("out_count", int'(out_count), int'(e.count));
        if (e.chk_lat) check_val("pulse_cycle", cyc, e.due);
      end
    end
  end

  // Drives one beat and waits (bounded) until it is taken.
  task automatic send_beat(input logic [LANES*DW-1:0] d, input logic last);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int w = 0; w < 64 && !ok; w++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL beat_accept: got in_ready=0 for 64 cycles want 1");
    end
  endtask

  // Element i of the vector is base (+ i when inc). Pushes the expectation when
  // the final beat is taken.
  task automatic send_vector(input int nbeats, input logic [15:0] base, input bit inc,
                             input bit last_full, input int exp_count, input bit chk_lat);
    exp_t                e;
    logic [LANES*DW-1:0] d;
    logic [15:0]         el;
    e.flat = '0;
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < LANES; j++) begin
        el = inc ? base + 16'(b * LANES + j) : base;
        d[j*DW +: DW] = el;
        e.flat[(b*LANES + j)*DW +: DW] = el;
      end
      send_beat(d, (b == nbeats - 1) && (nbeats < BEATS || last_full));
    end
    e.count   = CW'(exp_count);
    e.due     = cyc;
    e.chk_lat = chk_lat;
    sb.push_back(e);
    pushed++;
    last_exp = e;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && sb.size() != 0; w++) @(posedge clk);
    #1;
    check_val("drain_left", sb.size(), 0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8, 16'h3C00, 1'b1, 1'b0, 128};  // full, incrementing
    tbl[1] = '{3, 16'h4000, 1'b0, 1'b0, 48};   // short, padded
    tbl[2] = '{8, 16'h5000, 1'b1, 1'b1, 128};  // in_last on final beat
    tbl[3] = '{1, 16'h7E00, 1'b0, 1'b0, 16};   // NaN single beat
    tbl[4] = '{5, 16'h7C00, 1'b0, 1'b0, 80};   // Inf short
    tbl[5] = '{8, 16'h0001, 1'b1, 1'b0, 128};  // full after short: no residue

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    out_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", int'(in_ready), 1);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_count", int'(out_count), 0);
    check_flat("rst_out_flat", out_flat, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors streamed back to back; each pulse due the cycle after its last beat.
    for (int v = 0; v < 6; v++)
      send_vector(tbl[v].nbeats, tbl[v].base, tbl[v].inc, tbl[v].last_full,
                  tbl[v].exp_count, 1'b1);
    idle();
    drain();

    // Release of the first vector on the same edge as the second one completes.
    send_vector(1, 16'hAAAA, 1'b0, 1'b0, 16, 1'b1);
    send_vector(1, 16'h5555, 1'b1, 1'b0, 16, 1'b1);
    idle();
    drain();

    // Stall: hold with nothing pending has no effect, then freezes the result.
    out_hold = 1'b1;
    send_vector(8, 16'h1200, 1'b1, 1'b0, 128, 1'b0);
    fork
      send_vector(8, 16'h2300, 1'b1, 1'b0, 128, 1'b1);
      begin
        exp_t held;
        held = last_exp;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check_val("stall_in_ready", int'(in_ready), 0);
          check_val("stall_out_valid", int'(out_valid), 0);
          check_flat("stall_out_flat", out_flat, held.flat);
        end
        @(posedge clk);
        #1;
        out_hold = 1'b0;
      end
    join
    idle();
    drain();

    // Reset mid-vector discards the partial vector.
    for (int b = 0; b < 4; b++) send_beat({LANES{16'hDEAD}}, 1'b0);
    idle();
    rst_n = 1'b0;
    #2;
    check_val("midrst_out_valid", int'(out_valid), 0);
    check_val("midrst_out_count", int'(out_count), 0);
    check_val("midrst_in_ready", int'(in_ready), 1);
    check_flat("midrst_out_flat", out_flat, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_vector(8, 16'h6100, 1'b1, 1'b0, 128, 1'b1);
    send_vector(2, 16'h6200, 1'b0, 1'b0, 32, 1'b1);
    idle();
    drain();

    repeat (3) @(posedge clk);
    #1;
    check_val("pulse_total", pulses, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
